// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping MSI bus controller: round-robin arbitration of dcache
// transactions onto one RAM port, with snoop and cache-to-cache forwarding.
module coherence_bus_ctrl #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned SNOOP_CYC = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [1:0]          cctrans,
    input  logic [1:0]          ccwrite,
    input  logic [1:0]          dREN,
    input  logic [1:0]          dWEN,
    input  logic [2*WORD_W-1:0] daddr,
    input  logic [2*WORD_W-1:0] dstore,
    output logic [1:0]          dwait,
    output logic [2*WORD_W-1:0] dload,
    output logic [1:0]          ccwait,
    output logic [1:0]          ccinv,
    output logic [2*WORD_W-1:0] ccsnoopaddr,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [WORD_W-1:0]   ramaddr,
    output logic [WORD_W-1:0]   ramstore,
    input  logic [WORD_W-1:0]   ramload,
    input  logic                ram_ready
);
    typedef enum logic [2:0] {S_IDLE, S_WB, S_SNOOP, S_FWD, S_FWDLD, S_MEMLD} state_t;

    localparam logic [2:0] LP_LAST = 3'(SNOOP_CYC - 1);

    state_t              r_state, w_nstate;
    logic                r_g, r_rr, r_wcnt, r_pend, r_served;
    logic [2:0]          r_cnt;
    logic [WORD_W-1:0]   r_buf [2];

    logic [WORD_W-1:0]   w_addr  [2];
    logic [WORD_W-1:0]   w_store [2];
    logic [1:0]          w_req;
    logic                w_o, w_gnt, w_done, w_cap, w_dl_en;
    logic [WORD_W-1:0]   w_dl_val;

    assign w_addr[0]  = daddr[WORD_W-1:0];
    assign w_addr[1]  = daddr[2*WORD_W-1:WORD_W];
    assign w_store[0] = dstore[WORD_W-1:0];
    assign w_store[1] = dstore[2*WORD_W-1:WORD_W];
    assign w_req      = cctrans | dWEN | dREN;
    assign w_o        = ~r_g;

    always_comb begin
        w_nstate    = r_state;
        w_gnt       = r_g;
        w_done      = 1'b0;
        w_cap       = 1'b0;
        w_dl_en     = 1'b0;
        w_dl_val    = '0;
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_gnt = (&w_req) ? r_rr : w_req[1];
                    if (cctrans[w_gnt])   w_nstate = S_SNOOP;
                    else if (dWEN[w_gnt]) w_nstate = S_WB;
                    else                  w_nstate = S_MEMLD;
                end
            end
            S_WB: begin
                if (dWEN[r_g]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = w_addr[r_g];
                    ramstore = w_store[r_g];
                    if (ram_ready) dwait[r_g] = 1'b0;
                end else begin
                    w_nstate = S_IDLE;
                    w_done   = 1'b1;
                end
            end
            S_SNOOP, S_FWD: begin
                // Requester also sees ccwait so an S->M upgrade observes its falling edge.
                ccwait      = '1;
                ccsnoopaddr = {2{w_addr[r_g]}};
                ccinv[w_o]  = ccwrite[r_g];
                if (r_state == S_SNOOP) begin
                    if (r_cnt == LP_LAST) begin
                        if (ccwrite[w_o])   w_nstate = S_FWD;
                        else if (dREN[r_g]) w_nstate = S_MEMLD;
                        else begin
                            w_nstate = S_IDLE;
                            w_done   = 1'b1;
                        end
                    end
                end else if (dWEN[w_o]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = w_addr[w_o];
                    ramstore = w_store[w_o];
                    if (ram_ready) begin
                        dwait[w_o] = 1'b0;
                        w_cap      = 1'b1;
                        if (r_wcnt) w_nstate = S_FWDLD;
                    end
                end
            end
            S_FWDLD: begin
                if (r_pend) begin
                    dwait[r_g] = 1'b0;
                    w_dl_en    = 1'b1;
                    w_dl_val   = r_buf[w_addr[r_g][2]];
                    if (r_served) begin
                        w_nstate = S_IDLE;
                        w_done   = 1'b1;
                    end
                end else if (!dREN[r_g] && r_served) begin
                    w_nstate = S_IDLE;
                    w_done   = 1'b1;
                end
            end
            S_MEMLD: begin
                if (dREN[r_g]) begin
                    ramREN  = 1'b1;
                    ramaddr = w_addr[r_g];
                    if (ram_ready) begin
                        dwait[r_g] = 1'b0;
                        w_dl_en    = 1'b1;
                        w_dl_val   = ramload;
                    end
                end else begin
                    w_nstate = S_IDLE;
                    w_done   = 1'b1;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
        if (w_dl_en) begin
            if (r_g) dload[2*WORD_W-1:WORD_W] = w_dl_val;
            else     dload[WORD_W-1:0]        = w_dl_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_g      <= 1'b0;
            r_rr     <= 1'b0;
            r_cnt    <= '0;
            r_wcnt   <= 1'b0;
            r_pend   <= 1'b0;
            r_served <= 1'b0;
            r_buf    <= '{default: '0};
        end else begin
            r_state <= w_nstate;
            if (r_state == S_IDLE) begin
                r_g      <= w_gnt;
                r_cnt    <= '0;
                r_wcnt   <= 1'b0;
                r_pend   <= 1'b0;
                r_served <= 1'b0;
            end
            if (r_state == S_SNOOP) r_cnt <= r_cnt + 3'd1;
            if (w_cap) begin
                r_buf[w_addr[w_o][2]] <= w_store[w_o];
                r_wcnt                <= 1'b1;
            end
            if (r_state == S_FWDLD) begin
                if (r_pend) begin
                    r_pend   <= 1'b0;
                    r_served <= 1'b1;
                end else if (dREN[r_g]) begin
                    r_pend <= 1'b1;
                end
            end
            if (w_done) r_rr <= ~r_g;
        end
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Table-driven bench for coherence_bus_ctrl: per-cycle input/expected-output
// records, plus a hand-written writeback sequence with variable RAM latency.
module tb_coherence_bus_ctrl;
    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  cctrans, ccwrite, dREN, dWEN;
    logic [63:0] daddr, dstore;
    logic [1:0]  dwait, ccwait, ccinv;
    logic [63:0] dload, ccsnoopaddr;
    logic        ramREN, ramWEN, ram_ready;
    logic [31:0] ramaddr, ramstore, ramload;

    int n_checks = 0;
    int n_errors = 0;

    coherence_bus_ctrl #(.WORD_W(32), .SNOOP_CYC(1)) dut (
        .CLK(CLK), .RST(RST), .cctrans(cctrans), .ccwrite(ccwrite),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
        .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rst;
        logic [1:0]  cct, ccw, ren, wen;
        logic [31:0] a0, a1, s0, s1, rl;
        logic        rdy;
    } in_t;

    typedef struct packed {
        logic [1:0]  dw, cw, ci;
        logic        rren, rwen;
        logic [31:0] raddr, rstore, dl0, dl1, sa0, sa1;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];

    function automatic in_t I(input logic rst = 1'b0, input logic [1:0] cct = 2'b00,
                              input logic [1:0] ccw = 2'b00, input logic [1:0] ren = 2'b00,
                              input logic [1:0] wen = 2'b00, input logic [31:0] a0 = 32'h0,
                              input logic [31:0] a1 = 32'h0, input logic [31:0] s0 = 32'h0,
                              input logic [31:0] s1 = 32'h0, input logic [31:0] rl = 32'h0,
                              input logic rdy = 1'b0);
        in_t x;
        x = {rst, cct, ccw, ren, wen, a0, a1, s0, s1, rl, rdy};
        return x;
    endfunction

    function automatic out_t O(input logic [1:0] dw = 2'b11, input logic [1:0] cw = 2'b00,
                               input logic [1:0] ci = 2'b00, input logic rren = 1'b0,
                               input logic rwen = 1'b0, input logic [31:0] raddr = 32'h0,
                               input logic [31:0] rstore = 32'h0, input logic [31:0] dl0 = 32'h0,
                               input logic [31:0] dl1 = 32'h0, input logic [31:0] sa0 = 32'h0,
                               input logic [31:0] sa1 = 32'h0);
        out_t x;
        x = {dw, cw, ci, rren, rwen, raddr, rstore, dl0, dl1, sa0, sa1};
        return x;
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t x);
        RST       = x.rst;
        cctrans   = x.cct;
        ccwrite   = x.ccw;
        dREN      = x.ren;
        dWEN      = x.wen;
        daddr     = {x.a1, x.a0};
        dstore    = {x.s1, x.s0};
        ramload   = x.rl;
        ram_ready = x.rdy;
    endtask

    function automatic out_t sample();
        out_t x;
        x = {dwait, ccwait, ccinv, ramREN, ramWEN, ramaddr, ramstore,
             dload[31:0], dload[63:32], ccsnoopaddr[31:0], ccsnoopaddr[63:32]};
        return x;
    endfunction

    task automatic step(input in_t x);
        @(negedge CLK);
        drive(x);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        out_t act;
        int   n;

        // reset state
        add(I(1), O());
        // plain read, core0, 0x100/0x104
        add(I(0, 2'b00, 2'b00, 2'b01, 2'b00, 32'h100), O());
        add(I(0, 0, 0, 2'b01, 0, 32'h100), O(2'b11, 0, 0, 1, 0, 32'h100));
        add(I(0, 0, 0, 2'b01, 0, 32'h100, 0, 0, 0, 32'hAAAA0001, 1),
            O(2'b10, 0, 0, 1, 0, 32'h100, 0, 32'hAAAA0001));
        add(I(0, 0, 0, 2'b01, 0, 32'h104), O(2'b11, 0, 0, 1, 0, 32'h104));
        add(I(0, 0, 0, 2'b01, 0, 32'h104, 0, 0, 0, 32'hAAAA0002, 1),
            O(2'b10, 0, 0, 1, 0, 32'h104, 0, 32'hAAAA0002));
        add(I(0, 0, 0, 0, 0, 32'h104), O());
        add(I(0), O());
        // core0 coherent read 0x200, core1 clean: snoop then RAM
        add(I(0, 2'b01, 0, 2'b01, 0, 32'h200), O());
        add(I(0, 2'b01, 0, 2'b01, 0, 32'h200), O(2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 32'h200, 32'h200));
        add(I(0, 2'b01, 0, 2'b01, 0, 32'h200), O(2'b11, 0, 0, 1, 0, 32'h200));
        add(I(0, 2'b01, 0, 2'b01, 0, 32'h200, 0, 0, 0, 32'h11110000, 1),
            O(2'b10, 0, 0, 1, 0, 32'h200, 0, 32'h11110000));
        add(I(0), O());
        // core1 coherent write 0x300, core0 holds M: forward + writeback
        add(I(0, 2'b10, 2'b10, 2'b10, 0, 0, 32'h300), O());
        add(I(0, 2'b10, 2'b11, 2'b10, 0, 0, 32'h300),
            O(2'b11, 2'b11, 2'b01, 0, 0, 0, 0, 0, 0, 32'h300, 32'h300));
        add(I(0, 2'b10, 2'b11, 2'b10, 2'b01, 32'h300, 32'h300, 32'hDEAD0000),
            O(2'b11, 2'b11, 2'b01, 0, 1, 32'h300, 32'hDEAD0000, 0, 0, 32'h300, 32'h300));
        add(I(0, 2'b10, 2'b11, 2'b10, 2'b01, 32'h300, 32'h300, 32'hDEAD0000, 0, 0, 1),
            O(2'b10, 2'b11, 2'b01, 0, 1, 32'h300, 32'hDEAD0000, 0, 0, 32'h300, 32'h300));
        add(I(0, 2'b10, 2'b11, 2'b10, 2'b01, 32'h304, 32'h300, 32'hDEAD0004),
            O(2'b11, 2'b11, 2'b01, 0, 1, 32'h304, 32'hDEAD0004, 0, 0, 32'h300, 32'h300));
        add(I(0, 2'b10, 2'b11, 2'b10, 2'b01, 32'h304, 32'h300, 32'hDEAD0004, 0, 0, 1),
            O(2'b10, 2'b11, 2'b01, 0, 1, 32'h304, 32'hDEAD0004, 0, 0, 32'h300, 32'h300));
        add(I(0, 2'b10, 2'b10, 2'b10, 0, 32'h304, 32'h300), O());
        add(I(0, 2'b10, 2'b10, 2'b10, 0, 32'h304, 32'h300), O(2'b01, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD0000));
        add(I(0, 2'b10, 2'b10, 2'b10, 0, 32'h304, 32'h304), O());
        add(I(0, 2'b10, 2'b10, 2'b10, 0, 32'h304, 32'h304), O(2'b01, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD0004));
        add(I(0), O());
        // upgrade: core0 S->M, no data
        add(I(0, 2'b01, 2'b01, 0, 0, 32'h400), O());
        add(I(0, 2'b01, 2'b01, 0, 0, 32'h400), O(2'b11, 2'b11, 2'b10, 0, 0, 0, 0, 0, 0, 32'h400, 32'h400));
        add(I(0), O());
        // simultaneous COH after reset
        add(I(1), O());
        add(I(0, 2'b11, 0, 2'b11, 0, 32'h500, 32'h600), O());
        add(I(0, 2'b11, 0, 2'b11, 0, 32'h500, 32'h600), O(2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h500, 32'h500));
        add(I(0, 2'b11, 0, 2'b11, 0, 32'h500, 32'h600, 0, 0, 32'h55, 1),
            O(2'b10, 0, 0, 1, 0, 32'h500, 0, 32'h55));
        add(I(0, 2'b10, 0, 2'b10, 0, 32'h500, 32'h600), O());
        add(I(0, 2'b10, 0, 2'b10, 0, 32'h500, 32'h600), O());
        add(I(0, 2'b10, 0, 2'b10, 0, 32'h500, 32'h600), O(2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h600, 32'h600));
        add(I(0, 2'b10, 0, 2'b10, 0, 32'h500, 32'h600, 0, 0, 32'h66, 1),
            O(2'b01, 0, 0, 1, 0, 32'h600, 0, 0, 32'h66));
        add(I(0), O());
        // repeated collision: pointer 0 -> core0, then pointer 1 -> core1
        add(I(0, 2'b11, 2'b01, 0, 0, 32'h700, 32'h800), O());
        add(I(0, 2'b11, 2'b01, 0, 0, 32'h700, 32'h800), O(2'b11, 2'b11, 2'b10, 0, 0, 0, 0, 0, 0, 32'h700, 32'h700));
        add(I(0, 2'b11, 2'b01, 0, 0, 32'h700, 32'h800), O());
        add(I(0, 2'b11, 2'b00, 0, 0, 32'h700, 32'h800), O(2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 32'h800, 32'h800));
        add(I(0), O());
        // reset asserted mid-FWD
        add(I(0, 2'b01, 2'b01, 2'b01, 0, 32'h900), O());
        add(I(0, 2'b01, 2'b11, 2'b01, 0, 32'h900), O(2'b11, 2'b11, 2'b10, 0, 0, 0, 0, 0, 0, 32'h900, 32'h900));
        add(I(0, 2'b01, 2'b11, 2'b01, 2'b10, 32'h900, 32'h900, 0, 32'hBEEF),
            O(2'b11, 2'b11, 2'b10, 0, 1, 32'h900, 32'hBEEF, 0, 0, 32'h900, 32'h900));
        add(I(1, 2'b01, 2'b11, 2'b01, 2'b10, 32'h900, 32'h900, 0, 32'hBEEF),
            O(2'b11, 2'b11, 2'b10, 0, 1, 32'h900, 32'hBEEF, 0, 0, 32'h900, 32'h900));
        add(I(0, 2'b01, 2'b11, 2'b01, 2'b10, 32'h900, 32'h900, 0, 32'hBEEF), O());

        drive(I(1));
        repeat (2) @(posedge CLK);

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].i);
            act = sample();
            n_checks++;
            if (act !== tbl[k].o) begin
                n_errors++;
                $display("FAIL vec%0d got=%h exp=%h", k, act, tbl[k].o);
            end
        end

        // core1 writeback, second word with three cycles of RAM latency
        step(I(1));
        step(I(0, 0, 0, 0, 2'b10, 0, 32'hA00, 0, 32'h12345678));
        chk("wb_idle", {62'(dwait), ramWEN, ramREN}, {62'(2'b11), 1'b0, 1'b0});
        step(I(0, 0, 0, 0, 2'b10, 0, 32'hA00, 0, 32'h12345678));
        chk("wb_w0_bus", {ramaddr, ramstore}, {32'hA00, 32'h12345678});
        chk("wb_w0_ctl", {62'(dwait), ramWEN, ramREN}, {62'(2'b11), 1'b1, 1'b0});
        step(I(0, 0, 0, 0, 2'b10, 0, 32'hA00, 0, 32'h12345678, 0, 1));
        chk("wb_w0_done", 64'(dwait), 64'(2'b01));
        n = 0;
        while (n < 10) begin
            step(I(0, 0, 0, 0, 2'b10, 0, 32'hA04, 0, 32'h9ABCDEF0, 0, logic'(n == 3)));
            if (dwait[1] == 1'b0) break;
            n++;
        end
        chk("wb_w1_latency", 64'(n), 64'd3);
        chk("wb_w1_bus", {ramaddr, ramstore}, {32'hA04, 32'h9ABCDEF0});
        step(I(0));
        chk("wb_exit", {62'(dwait), ramWEN, ramREN}, {62'(2'b11), 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
